// File: rtl/tx_sr_ctrl.sv
// tx_sr_ctrl: load/shift sequencer for the 128-to-64 transmit shift register with valid/ready on both sides.
// Optional stall watchdog enabled by defining TX_STALL_TIMEOUT_EN.
module tx_sr_ctrl #(
  parameter int WORDS_PER_BLOCK = 2,
  parameter int CNT_W = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_enable,
  output logic             shift_enable,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             stall_err
);
  localparam int WC_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [WC_W-1:0] LAST = WC_W'(WORDS_PER_BLOCK - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [WC_W-1:0] word_cnt;
  logic abort;
  always_comb begin
    in_ready = 1'b0;
    load_enable = 1'b0;
    shift_enable = 1'b0;
    tx_valid = 1'b0;
    tx_last = 1'b0;
    busy = 1'b0;
    state_nxt = state;
    if (state == IDLE) begin
      in_ready = ~rst;
      load_enable = in_valid & ~rst;
      state_nxt = in_valid ? SEND : IDLE;
    end else begin
      tx_valid = 1'b1;
      busy = 1'b1;
      tx_last = word_cnt == LAST;
      in_ready = tx_ready & tx_last;
      load_enable = in_ready & in_valid;
      shift_enable = tx_ready & ~tx_last;
      state_nxt = (abort || (in_ready && !in_valid)) ? IDLE : SEND;
    end
  end
  // An accepted last word (in_ready while sending) completes a block.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      blk_cnt <= '0;
    end else begin
      state <= state_nxt;
      word_cnt <= load_enable ? '0 : shift_enable ? word_cnt + 1'b1 : word_cnt;
      blk_cnt <= blk_cnt + CNT_W'(in_ready & tx_valid);
    end
`ifdef TX_STALL_TIMEOUT_EN
  localparam int SW = $clog2(STALL_LIMIT);
  logic [SW-1:0] stall_cnt;
  logic stalled;
  assign stalled = tx_valid & ~tx_ready;
  assign abort = stalled && stall_cnt == SW'(STALL_LIMIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_cnt <= (stalled && !abort) ? stall_cnt + 1'b1 : '0;
      stall_err <= stall_err | abort;
    end
`else
  assign abort = 1'b0;
  assign stall_err = 1'b0;
`endif
endmodule
